crc_frame_gen: RTL and testbench
================================

Name: crc_frame_gen

Overview:
- Parametrised streaming CRC-32 generator for DAQ frame output.
- Sits between the frame builder and the serializer/FIFO.
- Passes data words through with valid/ready handshaking, accumulates CRC-32 over words flagged for calculation, and appends the finished CRC as trailer words after end-of-frame.
- Replaces the fixed 16-bit, shift-out-by-caller generator with width-generic datapath and self-sequenced append.

Parameters:
- DATA_W, 16, data word width; legal values 8, 16, 32.
- CRC_INIT, 32'hFFFFFFFF, CRC register value at reset and at each start-of-frame.
- APPEND_EN, 1, 1 = append CRC trailer words after eop; 0 = pass-through only, CRC on crc_out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_W  input word
- in_valid  in  1  input word valid
- in_sop  in  1  first word of frame; qualified by in_valid
- in_eop  in  1  last word of frame; qualified by in_valid
- in_calc  in  1  include this word in CRC; 0 = pass without update
- in_ready  out  1  block accepts input this cycle
- out_data  out  DATA_W  output word
- out_valid  out  1  output word valid
- out_eop  out  1  last output word of frame (last CRC word if APPEND_EN)
- out_ready  in  1  downstream accepts output
- crc_out  out  32  final CRC of last frame (complemented, reflected)
- crc_done  out  1  one-cycle pulse when crc_out updates

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset; no asynchronous reset.
- CRC algorithm:
  - Standard CRC-32, polynomial 0x04C11DB7, reflected.
  - Word bit 0 is processed first.
  - Final value = ~reflected register.
  - Check value: "123456789" gives 0xCBF43926.
- Next-state function:
  - One combinational step per DATA_W-bit word.
  - Generated by unrolling a 1-bit LFSR DATA_W times (for-loop function); no hand-written XOR tables.
- Reset values:
  - crc_reg = CRC_INIT.
  - out_valid, out_eop, crc_done = 0.
  - out_data = 0; crc_out = 32'h0.
  - FSM = IDLE.
- Output stage:
  - One-entry register slice; one-cycle latency from input accept to out_valid.
  - in_ready = ~out_valid | out_ready while state is IDLE or DATA; in_ready = 0 in APPEND.
- A word is accepted when in_valid & in_ready. On accept:
  - If in_sop: CRC updates from CRC_INIT, not from crc_reg.
  - If in_calc: crc_reg <= next(crc_reg or CRC_INIT, in_data).
  - If ~in_calc: crc_reg is held, or set to CRC_INIT if in_sop.
- FSM states:
  - IDLE: waiting for an sop word. A word accepted without in_sop passes through, and the CRC still updates.
  - IDLE -> DATA: on an accepted in_sop & ~in_eop.
  - DATA -> APPEND: on an accepted in_eop when APPEND_EN=1. The eop word is output with out_eop = 0. The final CRC is latched into crc_out and crc_done pulses.
  - DATA -> IDLE: on an accepted in_eop when APPEND_EN=0. The eop word is output with out_eop = 1. crc_out latches and crc_done pulses.
  - APPEND: emits N = 32/DATA_W trailer words, least-significant DATA_W slice of crc_out first. A word counter advances only on out_valid & out_ready. The last word has out_eop = 1; then return to IDLE.
- Single-word frame (in_sop & in_eop together): CRC computed from CRC_INIT over that word, then follow the eop rules above.
- Backpressure: out_data, out_valid and out_eop are held stable while out_valid & ~out_ready. No word is dropped or duplicated.
- in_sop while in DATA (missing eop): frame restarts. CRC reinitialises; no trailer is emitted for the aborted frame; FSM stays in DATA.
- Reset mid-frame or mid-append: the frame is abandoned, all state goes to reset values, and out_valid drops the next cycle.
- crc_out holds its value until the next eop.

Decomposition:
- Package crc_pkg holds:
  - constants CRC32_POLY and CRC32_INIT;
  - function crc32_step(crc, data) parametrised by width via an unrolled loop;
  - the FSM state enum {IDLE, DATA, APPEND}.
- One natural sub-module: crc32_comb (DATA_W parameter, purely combinational next-CRC). It can be reused by the receive-side checker.

Test Plan:
- DATA_W=8, frame 0x31..0x39 with sop/eop and out_ready=1:
  - output is 9 data bytes, then 0x26, 0x39, 0xF4, 0xCB;
  - out_eop is asserted on 0xCB;
  - crc_out = 0xCBF43926.
- DATA_W=16, words 0x3231, 0x3433, 0x3635, 0x3837:
  - trailer words are 0xDAAF, then 0x9AE0;
  - crc_out = 0x9AE0DAAF.
- DATA_W=16, same frame with out_ready toggled on a random 50% pattern:
  - output sequence is identical to the previous case;
  - out_data is stable whenever stalled;
  - in_ready = 0 during both trailer words.
- DATA_W=16, in_calc=0 on the first word (0xFFFF), then the four words above with in_calc=1:
  - the trailer is still 0xDAAF, 0x9AE0;
  - the 0xFFFF word is passed through unchanged.
- Single-word frame, DATA_W=32, data 0x34333231 with sop & eop:
  - crc_out = CRC of "1234" = 0x9BE3E0A3;
  - exactly one trailer word, 0x9BE3E0A3, is emitted with out_eop = 1.
- Reset asserted during the APPEND word 0 stall:
  - next cycle out_valid = 0 and the FSM is in IDLE;
  - the following frame produces the correct CRC from CRC_INIT.

Source files
------------

// File: rtl/crc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc_pkg : CRC-32 constants, width-generic bit-serial step, frame FSM states
// Revision: 1.0
// ----------------------------------------------------------------------------
package crc_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } crc_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Reflected LFSR unrolled 'width' times; data bit 0 enters first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                               input logic [31:0] data,
                                               input int          width);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                c = (c >> 1) ^ ((c[0] ^ data[i]) ? reflect32(CRC32_POLY) : 32'h0);
            end
        end
        return c;
    endfunction

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_frame_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc_frame_gen_if : input/output stream and CRC result bundle for crc_frame_gen
// Revision: 1.0
// ----------------------------------------------------------------------------
interface crc_frame_gen_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_eop;
    logic              in_calc;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_eop;
    logic              out_ready;
    logic [31:0]       crc_out;
    logic              crc_done;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_calc, out_ready,
        input  in_ready, out_data, out_valid, out_eop, crc_out, crc_done
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_calc, out_ready,
        output in_ready, out_data, out_valid, out_eop, crc_out, crc_done
    );
endinterface : crc_frame_gen_if
`default_nettype wire

// File: rtl/crc32_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc32_comb : combinational next CRC-32 register for one DATA_W-bit word
// Revision: 1.0
// ----------------------------------------------------------------------------
module crc32_comb
    import crc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  wire logic [31:0]       crc_i,
    input  wire logic [DATA_W-1:0] data_i,
    output logic      [31:0]       crc_o
);

    assign crc_o = crc32_step(crc_i, 32'(data_i), DATA_W);

endmodule : crc32_comb
`default_nettype wire

// File: rtl/crc_frame_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc_frame_gen : streaming CRC-32 generator with pass-through and trailer append
// Revision: 1.0
// ----------------------------------------------------------------------------
module crc_frame_gen
    import crc_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [31:0] CRC_INIT  = CRC32_INIT,
    parameter bit          APPEND_EN = 1'b1
) (
    input wire logic       clk,
    input wire logic       reset,
    crc_frame_gen_if.slave bus
);

    localparam int         N_TRL = 32 / DATA_W;
    localparam int         CNT_W = 3;
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DATA   = DATA;
    localparam logic [1:0] ST_APPEND = APPEND;

    logic [1:0]        state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_eop_q, out_eop_d;
    logic [31:0]       crc_out_q, crc_out_d;
    logic              crc_done_q, crc_done_d;

    logic              w_out_free;
    logic              w_in_ready;
    logic              w_accept;
    logic [31:0]       w_crc_base;
    logic [31:0]       w_crc_step;
    logic [31:0]       w_crc_upd;
    logic [DATA_W-1:0] w_trl_word;

    assign w_out_free = ~out_valid_q | bus.out_ready;
    assign w_in_ready = (state_q != ST_APPEND) & w_out_free;
    assign w_accept   = bus.in_valid & w_in_ready;

    // A start-of-frame word always seeds from CRC_INIT, even when it restarts a frame.
    assign w_crc_base = bus.in_sop ? CRC_INIT : crc_q;

    crc32_comb #(
        .DATA_W (DATA_W)
    ) u_crc32_comb (
        .crc_i  (w_crc_base),
        .data_i (bus.in_data),
        .crc_o  (w_crc_step)
    );

    assign w_crc_upd  = bus.in_calc ? w_crc_step : w_crc_base;
    assign w_trl_word = DATA_W'(crc_out_q >> (DATA_W * int'(cnt_q)));

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_eop_d   = out_eop_q;
        crc_out_d   = crc_out_q;
        crc_done_d  = 1'b0;

        case (state_q)
            ST_APPEND: begin
                // cnt_q counts trailer words already loaded; the slot leaves on each handshake.
                if (out_valid_q & bus.out_ready) begin
                    if (cnt_q == CNT_W'(N_TRL)) begin
                        out_valid_d = 1'b0;
                        out_eop_d   = 1'b0;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_data_d  = w_trl_word;
                        out_valid_d = 1'b1;
                        out_eop_d   = (cnt_q == CNT_W'(N_TRL - 1));
                        cnt_d       = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                if (w_accept) begin
                    crc_d       = w_crc_upd;
                    out_data_d  = bus.in_data;
                    out_valid_d = 1'b1;
                    out_eop_d   = bus.in_eop & ~APPEND_EN;
                    if (bus.in_eop) begin
                        crc_out_d  = ~w_crc_upd;
                        crc_done_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = APPEND_EN ? ST_APPEND : ST_IDLE;
                    end else if (bus.in_sop) begin
                        state_d = ST_DATA;
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_eop_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_eop_q   <= 1'b0;
            crc_out_q   <= 32'h0;
            crc_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_eop_q   <= out_eop_d;
            crc_out_q   <= crc_out_d;
            crc_done_q  <= crc_done_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.crc_done  = crc_done_q;

endmodule : crc_frame_gen
`default_nettype wire

// File: tb/tb_crc_frame_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_crc_frame_gen : 8/16/32-bit instances checked against a byte-table CRC-32 model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_crc_frame_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tb_reset;
    int          tb_sel;
    logic [31:0] tb_data;
    logic        tb_valid, tb_sop, tb_eop, tb_calc, tb_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] crc_tab [256];
    logic [31:0] fr_data [$];
    bit          fr_calc [$];

    crc_frame_gen_if #(.DATA_W(8))  if8  ();
    crc_frame_gen_if #(.DATA_W(16)) if16 ();
    crc_frame_gen_if #(.DATA_W(32)) if32 ();

    crc_frame_gen #(.DATA_W(8))  u_dut8  (.clk(clk), .reset(tb_reset), .bus(if8.slave));
    crc_frame_gen #(.DATA_W(16)) u_dut16 (.clk(clk), .reset(tb_reset), .bus(if16.slave));
    crc_frame_gen #(.DATA_W(32)) u_dut32 (.clk(clk), .reset(tb_reset), .bus(if32.slave));

    assign if8.in_data    = tb_data[7:0];
    assign if8.in_valid   = tb_valid && (tb_sel == 0);
    assign if8.in_sop     = tb_sop;
    assign if8.in_eop     = tb_eop;
    assign if8.in_calc    = tb_calc;
    assign if8.out_ready  = tb_ready;
    assign if16.in_data   = tb_data[15:0];
    assign if16.in_valid  = tb_valid && (tb_sel == 1);
    assign if16.in_sop    = tb_sop;
    assign if16.in_eop    = tb_eop;
    assign if16.in_calc   = tb_calc;
    assign if16.out_ready = tb_ready;
    assign if32.in_data   = tb_data;
    assign if32.in_valid  = tb_valid && (tb_sel == 2);
    assign if32.in_sop    = tb_sop;
    assign if32.in_eop    = tb_eop;
    assign if32.in_calc   = tb_calc;
    assign if32.out_ready = tb_ready;

    logic [31:0] o_data, o_crc;
    logic        o_valid, o_eop, o_in_ready, o_done;

    always_comb begin
        case (tb_sel)
            0: begin
                o_data = 32'(if8.out_data); o_valid = if8.out_valid; o_eop = if8.out_eop;
                o_in_ready = if8.in_ready; o_crc = if8.crc_out; o_done = if8.crc_done;
            end
            1: begin
                o_data = 32'(if16.out_data); o_valid = if16.out_valid; o_eop = if16.out_eop;
                o_in_ready = if16.in_ready; o_crc = if16.crc_out; o_done = if16.crc_done;
            end
            default: begin
                o_data = if32.out_data; o_valid = if32.out_valid; o_eop = if32.out_eop;
                o_in_ready = if32.in_ready; o_crc = if32.crc_out; o_done = if32.crc_done;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard byte-at-a-time CRC-32: words split little-endian into bytes.
    function automatic logic [31:0] model_crc(input int w);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] word;
        logic [7:0]  b;
        for (int k = 0; k < fr_data.size(); k++) begin
            word = fr_data[k];
            if (fr_calc[k]) begin
                for (int j = 0; j < w / 8; j++) begin
                    b = word[8*j +: 8];
                    c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
                end
            end
        end
        return ~c;
    endfunction

    task automatic run_frame(input int s, input bit rnd);
        int          w, ntrl, ndata, total, idx, outn;
        logic [31:0] crc, mask;
        logic [31:0] exp_q [$];
        bit          done_pend, pv, pr;
        logic [31:0] pd;
        w     = (s == 0) ? 8 : (s == 1) ? 16 : 32;
        ntrl  = 32 / w;
        mask  = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        ndata = fr_data.size();
        crc   = model_crc(w);
        for (int k = 0; k < ndata; k++) exp_q.push_back(fr_data[k] & mask);
        for (int t = 0; t < ntrl; t++) exp_q.push_back((crc >> (t * w)) & mask);
        total = ndata + ntrl;
        idx = 0; outn = 0; done_pend = 0; pv = 0; pr = 1; pd = 0;
        for (int cyc = 0; cyc < 500 && outn < total; cyc++) begin
            @(negedge clk);
            tb_sel   = s;
            tb_valid = (idx < ndata);
            tb_data  = 32'h0;
            tb_calc  = 1'b0;
            if (idx < ndata) begin
                tb_data = fr_data[idx];
                tb_calc = fr_calc[idx];
            end
            tb_sop   = (idx == 0);
            tb_eop   = (idx == ndata - 1);
            tb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (done_pend) begin
                chk("crc_done", 32'(o_done), 32'h1);
                chk("crc_out", o_crc, crc);
                done_pend = 0;
            end
            if (pv && !pr) begin
                chk("stall_valid", 32'(o_valid), 32'h1);
                chk("stall_data", o_data, pd);
            end
            if (o_valid && outn >= ndata) chk("in_ready_trailer", 32'(o_in_ready), 32'h0);
            if (tb_valid && o_in_ready) begin
                if (tb_eop) done_pend = 1;
                idx++;
            end
            if (o_valid && tb_ready) begin
                chk("out_data", o_data, exp_q[outn]);
                chk("out_eop", 32'(o_eop), 32'(outn == total - 1));
                outn++;
            end
            pv = o_valid; pr = tb_ready; pd = o_data;
        end
        chk("frame_words", 32'(outn), 32'(total));
        @(negedge clk);
        tb_valid = 1'b0; tb_sop = 1'b0; tb_eop = 1'b0;
    endtask

    task automatic load_ascii16();
        fr_data.delete(); fr_calc.delete();
        for (int i = 0; i < 4; i++) begin
            fr_data.push_back(32'h3231 + 32'(i) * 32'h0202);
            fr_calc.push_back(1'b1);
        end
    endtask

    initial begin
        logic [31:0] c;
        int          idx, outn;
        bit          hit;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end

        tb_reset = 1'b1; tb_sel = 0; tb_data = 32'h0; tb_valid = 1'b0;
        tb_sop = 1'b0; tb_eop = 1'b0; tb_calc = 1'b0; tb_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid8", 32'(if8.out_valid), 32'h0);
        chk("rst_valid16", 32'(if16.out_valid), 32'h0);
        chk("rst_valid32", 32'(if32.out_valid), 32'h0);
        chk("rst_eop16", 32'(if16.out_eop), 32'h0);
        chk("rst_done32", 32'(if32.crc_done), 32'h0);
        chk("rst_data16", 32'(if16.out_data), 32'h0);
        chk("rst_crc8", if8.crc_out, 32'h0);
        chk("rst_in_ready8", 32'(if8.in_ready), 32'h1);
        tb_reset = 1'b0;

        // "123456789" on the 8-bit instance
        fr_data.delete(); fr_calc.delete();
        for (int i = 0; i < 9; i++) begin
            fr_data.push_back(32'h31 + 32'(i));
            fr_calc.push_back(1'b1);
        end
        run_frame(0, 1'b0);
        chk("check_value8", if8.crc_out, 32'hCBF43926);

        load_ascii16();
        run_frame(1, 1'b0);
        chk("ascii16", if16.crc_out, 32'h9AE0DAAF);

        run_frame(1, 1'b1);
        chk("ascii16_bp", if16.crc_out, 32'h9AE0DAAF);

        fr_data.push_front(32'hFFFF);
        fr_calc.push_front(1'b0);
        run_frame(1, 1'b1);
        chk("nocalc16", if16.crc_out, 32'h9AE0DAAF);

        fr_data.delete(); fr_calc.delete();
        fr_data.push_back(32'h34333231);
        fr_calc.push_back(1'b1);
        run_frame(2, 1'b0);
        chk("single32", if32.crc_out, 32'h9BE3E0A3);

        // Drive a frame into APPEND, stall on trailer word 0, then reset.
        load_ascii16();
        tb_sel = 1; idx = 0; outn = 0; hit = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            tb_valid = (idx < 4);
            tb_data  = (idx < 4) ? 32'h3231 + 32'(idx) * 32'h0202 : 32'h0;
            tb_sop   = (idx == 0);
            tb_eop   = (idx == 3);
            tb_calc  = 1'b1;
            tb_ready = (outn < 4);
            #1;
            if (!tb_ready && o_valid) begin
                chk("trl0_stall", o_data, 32'hDAAF);
                hit = 1;
            end else begin
                if (tb_valid && o_in_ready) idx++;
                if (o_valid && tb_ready) outn++;
            end
        end
        chk("reached_trl0", 32'(hit), 32'h1);
        tb_valid = 1'b0; tb_sop = 1'b0; tb_eop = 1'b0;
        tb_reset = 1'b1;
        @(negedge clk);
        tb_reset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 32'h0);
        chk("rst_mid_in_ready", 32'(o_in_ready), 32'h1);
        chk("rst_mid_crc", o_crc, 32'h0);
        run_frame(1, 1'b1);
        chk("after_rst16", if16.crc_out, 32'h9AE0DAAF);

        for (int r = 0; r < 9; r++) begin
            fr_data.delete(); fr_calc.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                fr_data.push_back($urandom);
                fr_calc.push_back($urandom_range(0, 9) < 7);
            end
            run_frame(r % 3, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_crc_frame_gen
`default_nettype wire
